sipo_dot_engine: RTL and testbench

Downstream consumer of the 18-word serial-in/parallel-out array shifter. On `start`, snapshots the shifter's 288-bit window (18 × 16-bit signed words) and computes its dot product against 18 locally stored 16-bit signed coefficients, one multiply-accumulate per cycle. Presents a registered 32-bit result with a one-cycle `done` pulse. The upstream shifter may keep shifting during computation because the window is captured at start.

---
 rtl/sipo_dot_pkg.sv | 27 ++
 rtl/sipo_dot_engine_mac16.sv | 30 +++
 rtl/sipo_dot_engine.sv | 118 +++++++++++
 tb/tb_sipo_dot_engine.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_dot_pkg.sv
// Shared constants, state encoding and result clamp for sipo_dot_engine.
// Saturation helper is used when SIPO_DOT_SAT_EN is defined.
package sipo_dot_pkg;

    localparam int WORDS = 18;
    localparam int W     = 16;
    localparam int ACC_W = 40;
    localparam int RES_W = 32;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sh00_7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] SAT_MIN = 40'shFF_8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [RES_W-1:0] sat32(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        if ($signed(a) > SAT_MAX) r = SAT_MAX;
        if ($signed(a) < SAT_MIN) r = SAT_MIN;
        return r[RES_W-1:0];
    endfunction

endpackage

// File: rtl/sipo_dot_engine_mac16.sv
// Signed 16x16 multiply feeding a 40-bit accumulator register.
// sum is the value the accumulator takes on the next enabled edge.
module mac16
    import sipo_dot_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W-1:0]      acc;
    logic signed [2*W-1:0] prod;

    assign prod = $signed(a) * $signed(b);
    assign sum  = acc + {{(ACC_W-2*W){prod[2*W-1]}}, prod};

    // accumulator: clear on new job, add one product per enabled cycle
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/sipo_dot_engine.sv
// Snapshots an 18-word window on start and forms its dot product with a
// local coefficient bank. Define SIPO_DOT_SAT_EN to clamp the 32-bit result.
module sipo_dot_engine
    import sipo_dot_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [WORDS*W-1:0] sipo_in,
    input  logic               start,
    input  logic               coef_we,
    input  logic [4:0]         coef_addr,
    input  logic [W-1:0]       coef_data,
    output logic               busy,
    output logic               done,
    output logic [RES_W-1:0]   result
);

    state_t           state;
    state_t           nxt;
    logic [4:0]       idx;
    logic [W-1:0]     win  [WORDS];
    logic [W-1:0]     coef [WORDS];
    logic             sh_vld;
    logic [4:0]       sh_addr;
    logic [W-1:0]     sh_data;
    logic             go;
    logic             last;
    logic             wr_ok;
    logic [W-1:0]     a_op;
    logic [W-1:0]     b_op;
    logic [ACC_W-1:0] acc_nxt;
    logic [RES_W-1:0] res_d;

    assign go    = (state == IDLE) && start;
    assign last  = (state == RUN) && (idx == 5'(WORDS-1));
    assign wr_ok = (state == IDLE) && coef_we && (coef_addr < 5'(WORDS));
    assign a_op  = win[idx];
    // a write landing with start must not affect this job: use saved value
    assign b_op  = (sh_vld && sh_addr == idx) ? sh_data : coef[idx];

`ifdef SIPO_DOT_SAT_EN
    assign res_d = sat32(acc_nxt);
`else
    logic unused_hi;
    assign res_d     = acc_nxt[RES_W-1:0];
    assign unused_hi = ^acc_nxt[ACC_W-1:RES_W];
`endif

    mac16 u_mac (
        .clk (clk),
        .rst (rst),
        .clr (go),
        .en  (state == RUN),
        .a   (a_op),
        .b   (b_op),
        .sum (acc_nxt)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // next-state decode
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (start) nxt = RUN;
            RUN:  if (last)  nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // word index, window snapshot and pre-write coefficient shadow
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            sh_vld  <= 1'b0;
            sh_addr <= '0;
            sh_data <= '0;
            for (int i = 0; i < WORDS; i++) win[i] <= '0;
        end else if (go) begin
            idx     <= '0;
            sh_vld  <= wr_ok;
            sh_addr <= coef_addr;
            sh_data <= wr_ok ? coef[coef_addr] : '0;
            for (int i = 0; i < WORDS; i++) win[i] <= sipo_in[W*i +: W];
        end else if (state == RUN) begin
            idx <= last ? '0 : idx + 5'd1;
        end
    end

    // coefficient bank, writable only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) coef[i] <= '0;
        end else if (wr_ok) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= last;
            if (go)                 busy <= 1'b1;
            else if (state == DONE) busy <= 1'b0;
            if (last) result <= res_d;
        end
    end

endmodule

// File: tb/tb_sipo_dot_engine.sv
// Directed bench for sipo_dot_engine: vector table plus corner sequences.
// Expected results follow SIPO_DOT_SAT_EN when it is defined.
module tb_sipo_dot_engine;
    import sipo_dot_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [WORDS*W-1:0] sipo_in;
    logic               start;
    logic               coef_we;
    logic [4:0]         coef_addr;
    logic [W-1:0]       coef_data;
    logic               busy;
    logic               done;
    logic [RES_W-1:0]   result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string              name;
        logic [WORDS*W-1:0] win;
        logic [WORDS*W-1:0] cf;
        logic [31:0]        exp;
    } vec_t;

    vec_t tv[6];
    logic [WORDS*W-1:0] ones;
    logic [WORDS*W-1:0] ramp;
    logic [31:0] res;
    int lat;
    int nd;

    always #5 clk = ~clk;

    sipo_dot_engine dut (
        .clk       (clk),
        .rst       (rst),
        .sipo_in   (sipo_in),
        .start     (start),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic load_coefs(input logic [WORDS*W-1:0] cf);
        for (int i = 0; i < WORDS; i++) begin
            coef_we   = 1'b1;
            coef_addr = 5'(i);
            coef_data = cf[W*i +: W];
            tick();
        end
        coef_we = 1'b0;
    endtask

    // start a job, wait for done, check latency, busy span and idle return
    task automatic run(input string nm, output logic [31:0] r);
        int n;
        int nb;
        n  = 0;
        nb = 0;
        start = 1'b1;
        do begin
            tick();
            n++;
            start   = 1'b0;
            coef_we = 1'b0;
            if (busy) nb++;
        end while (!done && n < 40);
        r = result;
        chk({nm, "_latency"}, n, 19);
        chk({nm, "_busy_cycles"}, nb, 19);
        tick();
        chk({nm, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        sipo_in   = '0;
        start     = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;

        for (int i = 0; i < WORDS; i++) begin
            ones[W*i +: W] = 16'd1;
            ramp[W*i +: W] = 16'(i + 1);
        end

        tv[0].name = "ramp_ones";
        tv[0].win  = ramp;
        tv[0].cf   = ones;
        tv[0].exp  = 32'd171;
        tv[1].name = "zero_coef";
        tv[1].win  = ramp;
        tv[1].cf   = '0;
        tv[1].exp  = 32'd0;
        tv[2].name = "min_min";
        for (int i = 0; i < WORDS; i++) begin
            tv[2].win[W*i +: W] = 16'h8000;
            tv[2].cf[W*i +: W]  = 16'h8000;
        end
`ifdef SIPO_DOT_SAT_EN
        tv[2].exp = 32'h7FFF_FFFF;
`else
        tv[2].exp = 32'h8000_0000;
`endif
        tv[3].name = "neg_coef";
        for (int i = 0; i < WORDS; i++) begin
            tv[3].win[W*i +: W] = 16'd100;
            tv[3].cf[W*i +: W]  = 16'hFFFD;
        end
        tv[3].exp = 32'hFFFF_EAE8;
        tv[4].name = "index_weight";
        for (int i = 0; i < WORDS; i++) begin
            tv[4].win[W*i +: W] = 16'(1000 * (i + 1));
            tv[4].cf[W*i +: W]  = 16'(i);
        end
        tv[4].exp = 32'd1938000;
        tv[5].name = "alt_sign";
        for (int i = 0; i < WORDS; i++) begin
            tv[5].win[W*i +: W] = 16'h7FFF;
            tv[5].cf[W*i +: W]  = (i % 2 == 0) ? 16'h7FFF : 16'h8001;
        end
        tv[5].exp = 32'd0;

        tick();
        tick();
        rst = 1'b0;
        chk("reset_outputs", {result[29:0], busy, done}, 32'd0);

        sipo_in = {9{32'hA5C3_1F07}};
        run("reset_zero_run", res);
        chk("reset_zero_result", res, 32'd0);

        for (int k = 0; k < 6; k++) begin
            load_coefs(tv[k].cf);
            sipo_in = tv[k].win;
            run(tv[k].name, res);
            chk({tv[k].name, "_result"}, res, tv[k].exp);
        end

        // snapshot: window churns, start and coef write mid-run are ignored
        load_coefs(ones);
        sipo_in = ramp;
        start   = 1'b1;
        nd      = 0;
        lat     = 0;
        res     = '0;
        for (int k = 0; k < 40; k++) begin
            tick();
            start   = 1'b0;
            coef_we = 1'b0;
            if (done) begin
                nd++;
                if (nd == 1) begin
                    lat = k + 1;
                    res = result;
                end
            end
            if (k < 17) sipo_in = {$urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom};
            if (k == 5) begin
                start     = 1'b1;
                coef_we   = 1'b1;
                coef_addr = 5'd0;
                coef_data = 16'd5;
            end
        end
        chk("snap_done_count", nd, 1);
        chk("snap_latency", lat, 19);
        chk("snap_result", res, 32'd171);
        sipo_in = ramp;
        run("coef0_kept", res);
        chk("coef0_kept_result", res, 32'd171);

        // write alongside start lands but this job uses the old value
        coef_we   = 1'b1;
        coef_addr = 5'd0;
        coef_data = 16'd10;
        run("wr_with_start", res);
        chk("wr_with_start_result", res, 32'd171);
        run("wr_landed", res);
        chk("wr_landed_result", res, 32'd180);

        // reset in the middle of RUN abandons the job
        load_coefs(ones);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done) nd++;
        end
        chk("midrst_no_done", nd, 0);
        chk("midrst_result", result, 32'd0);
        run("midrst_coef_cleared", res);
        chk("midrst_coef_cleared_result", res, 32'd0);
        load_coefs(ones);
        run("after_rst", res);
        chk("after_rst_result", res, 32'd171);

        // back-to-back: second start in the first idle cycle after done
        sipo_in = tv[4].win;
        load_coefs(tv[4].cf);
        run("b2b_first", res);
        chk("b2b_first_result", res, 32'd1938000);
        run("b2b_second", res);
        chk("b2b_second_result", res, 32'd1938000);

        // out-of-range coefficient address is dropped
        coef_we   = 1'b1;
        coef_addr = 5'd20;
        coef_data = 16'h7FFF;
        tick();
        coef_we = 1'b0;
        run("oob_addr", res);
        chk("oob_addr_result", res, 32'd1938000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
